// File: rtl/alu_issue_queue_pkg.sv
// Shared ALU definitions: opcode encoding, tag width and opcode classification helper.
package alu_issue_queue_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_SLT = 3'd7
    } opcode_e;

    localparam int ALU_TAG_W = 4;

    function automatic logic is_shift(opcode_e op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and first-word fall-through read.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1,
    localparam int IDX_W = PTR_W - 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [IDX_W-1:0] widx, ridx;
    logic             do_push, do_pop;

    assign widx  = wptr_q[IDX_W-1:0];
    assign ridx  = rptr_q[IDX_W-1:0];
    assign empty = (wptr_q == rptr_q);
    assign full  = (widx == ridx) && (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);
    assign count = CNT_W'(wptr_q - rptr_q);
    assign rdata = mem_q[ridx];

    // Flush discards any same-cycle transfer.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[widx] <= wdata;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order ALU command queue: masks shift amounts, tags each accepted command and
// presents the oldest entry to the ALU with outputs zeroed while empty.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = ALU_TAG_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  opcode_e          in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             alu_valid,
    input  logic             alu_ready,
    output opcode_e          alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [TAG_W-1:0] alu_tag,
    output logic [CNT_W-1:0] count
);

    typedef struct packed {
        opcode_e          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // WIDTH is a power of two, so WIDTH-1 is exactly the legal shift-amount field.
    localparam logic [WIDTH-1:0] SHAMT_MASK = WIDTH'(WIDTH - 1);

    entry_t           wr_entry, rd_entry;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [TAG_W-1:0] tag_q, tag_d;

    assign in_ready  = !fifo_full;
    assign alu_valid = !fifo_empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = alu_valid && alu_ready && !flush;

    always_comb begin
        wr_entry.op  = in_op;
        wr_entry.a   = in_a;
        wr_entry.b   = is_shift(in_op) ? (in_b & SHAMT_MASK) : in_b;
        wr_entry.tag = tag_q;
    end

    assign tag_d = push ? tag_q + TAG_W'(1) : tag_q;

    always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= tag_d;
    end

    alu_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_comb begin
        alu_op  = OP_ADD;
        alu_a   = '0;
        alu_b   = '0;
        alu_tag = '0;
        if (alu_valid) begin
            alu_op  = rd_entry.op;
            alu_a   = rd_entry.a;
            alu_b   = rd_entry.b;
            alu_tag = rd_entry.tag;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed-vector bench for alu_issue_queue (WIDTH=32, DEPTH=4, TAG_W=4).
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, alu_ready;
    opcode_e     in_op;
    logic [31:0] in_a, in_b;
    logic        in_ready, alu_valid;
    opcode_e     alu_op;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_tag;
    logic [2:0]  count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.WIDTH(32), .DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_tag   (alu_tag),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input opcode_e op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_ready = 1'b0;
        in_op = OP_ADD; in_a = '0; in_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("init_count", 64'(count), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd1);

        // Reset with queue half full
        push(OP_SUB, 32'd1, 32'd1);
        push(OP_SUB, 32'd2, 32'd2);
        chk("half_count", 64'(count), 64'd2);
        chk("half_tag", 64'(alu_tag), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(alu_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_op", 64'(alu_op), 64'd0);
        chk("rst_a", 64'(alu_a), 64'd0);
        chk("rst_b", 64'(alu_b), 64'd0);
        chk("rst_tag", 64'(alu_tag), 64'd0);

        // Single issue, held while alu_ready=0
        push(OP_ADD, 32'd5, 32'd7);
        chk("si_valid", 64'(alu_valid), 64'd1);
        chk("si_op", 64'(alu_op), 64'(OP_ADD));
        chk("si_a", 64'(alu_a), 64'd5);
        chk("si_b", 64'(alu_b), 64'd7);
        chk("si_tag", 64'(alu_tag), 64'd0);
        tick(); tick();
        chk("si_hold_a", 64'(alu_a), 64'd5);
        chk("si_hold_b", 64'(alu_b), 64'd7);
        chk("si_hold_valid", 64'(alu_valid), 64'd1);
        alu_ready = 1'b1; tick(); alu_ready = 1'b0;
        chk("si_drained", 64'(alu_valid), 64'd0);
        chk("si_count0", 64'(count), 64'd0);

        // Fill with 5 back-to-back pushes; 5th refused. Tags 1..4.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_op = OP_XOR; in_a = 32'(10 + i); in_b = 32'h0;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_tag", 64'(alu_tag), 64'(1 + i));
            chk("drain_a", 64'(alu_a), 64'(10 + i));
            tick();
        end
        alu_ready = 1'b0;
        chk("drain_empty", 64'(alu_valid), 64'd0);

        // Shift masking; tags 5,6,7
        push(OP_SLL, 32'h0, 32'h25);
        push(OP_SRL, 32'h0, 32'hFFFF_FFE0);
        push(OP_ADD, 32'hDEAD_BEEF, 32'h25);
        alu_ready = 1'b1;
        chk("sll_b", 64'(alu_b), 64'h05);
        chk("sll_tag", 64'(alu_tag), 64'd5);
        tick();
        chk("srl_b", 64'(alu_b), 64'h0);
        chk("srl_op", 64'(alu_op), 64'(OP_SRL));
        tick();
        chk("add_b", 64'(alu_b), 64'h25);
        chk("add_a", 64'(alu_a), 64'hDEAD_BEEF);
        tick();
        alu_ready = 1'b0;
        chk("shift_empty", 64'(alu_valid), 64'd0);

        // Concurrent push+pop at count=2; tags 8,9 then 10
        push(OP_OR, 32'h20, 32'h0);
        push(OP_OR, 32'h21, 32'h0);
        in_valid = 1'b1; alu_ready = 1'b1; in_op = OP_OR; in_a = 32'h22; in_b = 32'h0;
        tick();
        in_valid = 1'b0; alu_ready = 1'b0;
        chk("pp_count", 64'(count), 64'd2);
        chk("pp_head_tag", 64'(alu_tag), 64'd9);
        // Fill (tags 11,12), then push+pop while full: pop only
        push(OP_OR, 32'h23, 32'h0);
        push(OP_OR, 32'h24, 32'h0);
        chk("full_count", 64'(count), 64'd4);
        in_valid = 1'b1; alu_ready = 1'b1; in_a = 32'h99;
        tick();
        in_valid = 1'b0; alu_ready = 1'b0;
        chk("fullpp_count", 64'(count), 64'd3);
        chk("fullpp_in_ready", 64'(in_ready), 64'd1);
        chk("fullpp_head_tag", 64'(alu_tag), 64'd10);

        // Flush with concurrent push at count=3
        flush = 1'b1; in_valid = 1'b1; in_op = OP_ADD; in_a = 32'h77; in_b = 32'h0;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(alu_valid), 64'd0);
        chk("flush_a_zero", 64'(alu_a), 64'd0);
        push(OP_ADD, 32'h78, 32'h1);
        chk("post_flush_tag", 64'(alu_tag), 64'd13);
        chk("post_flush_a", 64'(alu_a), 64'h78);
        alu_ready = 1'b1; tick(); alu_ready = 1'b0;

        // Push into empty while alu_ready=1: no pop that cycle (tag 14)
        in_valid = 1'b1; alu_ready = 1'b1; in_op = OP_AND; in_a = 32'h5A; in_b = 32'h3;
        tick();
        in_valid = 1'b0;
        chk("empty_push_count", 64'(count), 64'd1);
        chk("empty_push_tag", 64'(alu_tag), 64'd14);
        tick();
        alu_ready = 1'b0;
        chk("empty_push_popped", 64'(count), 64'd0);

        // Tag wrap 15 -> 0
        push(OP_SUB, 32'h1, 32'h1);
        push(OP_SUB, 32'h2, 32'h2);
        chk("wrap_tag15", 64'(alu_tag), 64'd15);
        alu_ready = 1'b1; tick(); alu_ready = 1'b0;
        chk("wrap_tag0", 64'(alu_tag), 64'd0);
        chk("wrap_a", 64'(alu_a), 64'd2);

        // Mid-operation reset restarts tag at 0
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_count", 64'(count), 64'd0);
        push(OP_SLT, 32'h3, 32'h4);
        chk("rst2_tag", 64'(alu_tag), 64'd0);
        chk("rst2_op", 64'(alu_op), 64'(OP_SLT));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
